// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder built from one full-adder cell and a carry flip-flop.
// A start request loads two WIDTH-bit operands and a carry-in. The block
// then adds one bit per clock, LSB first. When the last bit is done it
// presents the registered sum and carry-out together with a one-cycle done
// pulse. This suits places where area matters more than latency.
//
// Parameters
//   WIDTH   operand/sum width in bits (>= 1)
//
// Ports
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request, accepted only while busy is low
//   a       in   WIDTH  operand A, captured when start is accepted
//   b       in   WIDTH  operand B, captured when start is accepted
//   c_i     in   1      carry-in, captured when start is accepted
//   busy    out  1      high while bit additions are in progress
//   done    out  1      one-cycle pulse when sum/c_o hold a new result
//   sum     out  WIDTH  registered sum, held until the next completion
//   c_o     out  1      registered carry-out, held until the next completion
// ---------------------------------------------------------------------------
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_i,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_o
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FIN
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             sum_bit;
   logic             carry_next;
   logic [WIDTH-1:0] acc_next;

   // The single full-adder cell works on the LSBs of the operand shift
   // registers. Its sum bit enters the accumulator at the MSB. After WIDTH
   // shifts, the first (LSB) result bit has therefore reached bit 0. The
   // insertion is written as a shift so that WIDTH=1 needs no special slice.
   always_comb begin
      sum_bit    = a_sr[0] ^ b_sr[0] ^ carry;
      carry_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
      acc_next   = (acc >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
   end

   // Control FSM together with the datapath registers.
   // IDLE and FIN behave alike: both accept a new request, and FIN accepting
   // one gives back-to-back operation. The sum and carry-out registers load
   // only on the edge that finishes the last bit, so the completed value is
   // stored directly from the adder cell. They hold that value through the
   // following operations until the next completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sr  <= '0;
         b_sr  <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         c_o   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE, FIN: begin
               done <= 1'b0;
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= c_i;
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            SHIFT: begin
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               acc   <= acc_next;
               carry <= carry_next;
               cnt   <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  sum   <= acc_next;
                  c_o   <= carry_next;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= FIN;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Directed bench for serial_adder. It drives an 8-bit instance and a 1-bit
// instance that share the same clock and reset. Expected values are worked
// out by hand and written as constants.
// ---------------------------------------------------------------------------
module tb_serial_adder;

   logic       clk;
   logic       rst_n;

   logic       start8;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       ci8;
   logic       busy8;
   logic       done8;
   logic [7:0] sum8;
   logic       co8;

   logic       start1;
   logic [0:0] a1;
   logic [0:0] b1;
   logic       ci1;
   logic       busy1;
   logic       done1;
   logic [0:0] sum1;
   logic       co1;

   int compareCount;
   int failCount;

   logic [1:0] faTable [8];

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .c_i   (ci8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .c_o   (co8)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start1),
      .a     (a1),
      .b     (b1),
      .c_i   (ci1),
      .busy  (busy1),
      .done  (done1),
      .sum   (sum1),
      .c_o   (co1)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // A single comparison point. Every check made by the bench goes through here.
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      compareCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Presents an 8-bit request. The caller must be at a falling edge.
   task automatic applyStimulus(input logic [7:0] aa, input logic [7:0] bb,
                                input logic cc);
      a8     = aa;
      b8     = bb;
      ci8    = cc;
      start8 = 1'b1;
   endtask

   // Follows an accepted 8-bit request through its eight addition cycles.
   // While the operation runs, busy must stay high, done must stay low and the
   // previous result must be held. At the end the bench checks the done pulse
   // and the new result.
   task automatic finishOp8(input string tag, input logic [7:0] heldSum,
                            input logic heldCo, input logic [7:0] expSum,
                            input logic expCo);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 0) start8 = 1'b0;
         checkOutput({tag, "_busy"}, 16'(busy8), 16'(1'b1));
         checkOutput({tag, "_nodone"}, 16'(done8), 16'(1'b0));
         checkOutput({tag, "_hold"}, 16'({heldCo, sum8}), 16'({co8, heldSum}));
      end
      @(negedge clk);
      checkOutput({tag, "_done"}, 16'(done8), 16'(1'b1));
      checkOutput({tag, "_idle"}, 16'(busy8), 16'(1'b0));
      checkOutput({tag, "_result"}, 16'({co8, sum8}), 16'({expCo, expSum}));
   endtask

   // Directed sequence, one scenario after another.
   initial begin
      compareCount = 0;
      failCount    = 0;
      faTable[0] = 2'b00;
      faTable[1] = 2'b01;
      faTable[2] = 2'b01;
      faTable[3] = 2'b10;
      faTable[4] = 2'b01;
      faTable[5] = 2'b10;
      faTable[6] = 2'b10;
      faTable[7] = 2'b11;

      rst_n  = 1'b0;
      start8 = 1'b0;
      a8     = '0;
      b8     = '0;
      ci8    = 1'b0;
      start1 = 1'b0;
      a1     = '0;
      b1     = '0;
      ci1    = 1'b0;

      $display("[TB] reset with random inputs");
      for (int k = 0; k < 3; k++) begin
         start8 = 1'($urandom);
         a8     = 8'($urandom);
         b8     = 8'($urandom);
         ci8    = 1'($urandom);
         start1 = 1'($urandom);
         a1     = 1'($urandom);
         b1     = 1'($urandom);
         ci1    = 1'($urandom);
         @(negedge clk);
         checkOutput("rst_w8", 16'({busy8, done8, co8, sum8}), 16'h0000);
         checkOutput("rst_w1", 16'({busy1, done1, co1, sum1}), 16'h0000);
      end
      start8 = 1'b0;
      start1 = 1'b0;
      rst_n  = 1'b1;
      @(negedge clk);
      checkOutput("post_rst", 16'({busy8, done8, co8, sum8}), 16'h0000);

      $display("[TB] width-1 full-adder truth table");
      for (int i = 0; i < 8; i++) begin
         a1     = 1'(i >> 2);
         b1     = 1'(i >> 1);
         ci1    = 1'(i);
         start1 = 1'b1;
         @(negedge clk);
         start1 = 1'b0;
         checkOutput("w1_busy", 16'({busy1, done1}), 16'b10);
         @(negedge clk);
         checkOutput("w1_done", 16'({busy1, done1}), 16'b01);
         checkOutput("w1_result", 16'({co1, sum1}), 16'(faTable[i]));
      end
      @(negedge clk);
      checkOutput("w1_pulse_end", 16'(done1), 16'(1'b0));

      $display("[TB] FF + 01 + 0");
      applyStimulus(8'hFF, 8'h01, 1'b0);
      finishOp8("ff01", 8'h00, 1'b0, 8'h00, 1'b1);
      @(negedge clk);
      checkOutput("ff01_pulse_end", 16'({busy8, done8}), 16'b00);
      checkOutput("ff01_held", 16'({co8, sum8}), 16'h100);

      $display("[TB] A5 + 5A + 1, then back-to-back A5 + 5A + 0");
      applyStimulus(8'hA5, 8'h5A, 1'b1);
      finishOp8("a55a_c1", 8'h00, 1'b1, 8'h00, 1'b1);
      applyStimulus(8'hA5, 8'h5A, 1'b0);
      finishOp8("a55a_c0", 8'h00, 1'b1, 8'hFF, 1'b0);
      start8 = 1'b0;
      @(negedge clk);
      checkOutput("b2b_pulse_end", 16'({busy8, done8}), 16'b00);

      $display("[TB] 12 + 34 with ignored start mid-operation");
      applyStimulus(8'h12, 8'h34, 1'b0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         start8 = (k == 2);
         a8     = (k == 2) ? 8'hFF : 8'h12;
         b8     = (k == 2) ? 8'hFF : 8'h34;
         ci8    = (k == 2);
         checkOutput("ign_busy", 16'({busy8, done8}), 16'b10);
      end
      @(negedge clk);
      checkOutput("ign_done", 16'({busy8, done8}), 16'b01);
      checkOutput("ign_result", 16'({co8, sum8}), 16'h046);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checkOutput("ign_single_done", 16'({busy8, done8}), 16'b00);
      end

      $display("[TB] reset mid-operation, then fresh request");
      applyStimulus(8'hFF, 8'hFF, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         start8 = 1'b0;
      end
      checkOutput("abort_busy", 16'(busy8), 16'(1'b1));
      rst_n = 1'b0;
      #1;
      checkOutput("abort_async", 16'({busy8, done8, co8, sum8}), 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checkOutput("abort_no_done", 16'({busy8, done8, co8, sum8}), 16'h0000);
      end
      applyStimulus(8'h03, 8'h04, 1'b0);
      finishOp8("fresh", 8'h00, 1'b0, 8'h07, 1'b0);
      start8 = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
